// File: rtl/shot_sched_pkg.sv
// Shared types and constants for the shot scheduler: state encoding,
// default sizes and the requester-index width helper.
package shot_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNT_W = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shot_scheduler_if.sv
// Requester/consumer bundle of the shot scheduler; the scheduler takes the
// slave view, the requesting side (or a bench) drives the master view.
interface shot_scheduler_if
    import shot_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]  req;
    logic [CNT_W-1:0] win_lo;
    logic [CNT_W-1:0] win_hi;
    logic             abort;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             shot_o;
    logic [ID_W-1:0]  shot_id;
    logic             done_o;
    logic             aborted_o;
    logic             cfg_err_o;

    modport master (
        output req, win_lo, win_hi, abort,
        input  gnt, busy, shot_o, shot_id, done_o, aborted_o, cfg_err_o
    );

    modport slave (
        input  req, win_lo, win_hi, abort,
        output gnt, busy, shot_o, shot_id, done_o, aborted_o, cfg_err_o
    );
endinterface

// File: rtl/shot_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr_q; the
// pointer moves past the winner only when en_i accepts the grant.
module rr_arbiter
    import shot_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);
    localparam int PW = id_width(NREQ);
    localparam int SW = PW + 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        logic [SW-1:0] sum;
        logic [PW-1:0] idx;
        logic          found;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en_i && |req_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shot_scheduler.sv
// Shares one windowed one-shot counter between NREQ requesters.
// Optional SHOT_GUARD_EN inserts GUARD_CYC idle cycles after every service.
module shot_scheduler
    import shot_sched_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GUARD_CYC = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    shot_scheduler_if.slave    bus
);
    localparam int ID_W = id_width(NREQ);
    localparam int GW   = id_width(GUARD_CYC + 1);
`ifdef SHOT_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    state_t           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [ID_W-1:0]  shot_id_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lo_q;
    logic [CNT_W-1:0] hi_q;
    logic             aborted_q;
    logic             cfg_err_q;
    logic [GW-1:0]    guard_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [ID_W-1:0]  win_id;
    logic             arb_en;

    assign arb_en = (state_q == ST_IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.req),
        .en_i  (arb_en),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        win_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                win_id = ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            shot_id_q <= '0;
            cnt_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
            guard_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q     <= arb_gnt;
                        shot_id_q <= win_id;
                        lo_q      <= bus.win_lo;
                        hi_q      <= bus.win_hi;
                        cnt_q     <= '0;
                        if (bus.win_lo <= bus.win_hi) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q   <= ST_DONE;
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Stop at hi_q instead of incrementing, so hi = max never wraps.
                    if (bus.abort) begin
                        state_q   <= ST_DONE;
                        aborted_q <= 1'b1;
                    end else if (cnt_q == hi_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt_q     <= '0;
                    aborted_q <= 1'b0;
                    cfg_err_q <= 1'b0;
                    if (GUARD_EN) begin
                        state_q <= ST_GUARD;
                        guard_q <= GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GUARD: begin
                    if (guard_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        guard_q <= guard_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.shot_o    = (state_q == ST_RUN) && (cnt_q >= lo_q);
    assign bus.shot_id   = shot_id_q;
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.aborted_o = aborted_q;
    assign bus.cfg_err_o = cfg_err_q;

endmodule
